// File: rtl/bus_select_pkg.sv
// Shared types, default widths and the region match helper for the
// 8088 bus select unit (address latch, region decode, wait states).
package bus_select_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA
    } bus_state_e;

    localparam int DEF_NUM_REGIONS = 4;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_IO_ADDR_W   = 16;
    localparam int DEF_WS_W        = 3;

    // Widest address the helper handles; callers zero-extend.
    localparam int ADDR_MAX = 32;

    // I/O windows only see the low io_w address bits.
    function automatic logic region_hit(
        input logic [ADDR_MAX-1:0] addr,
        input logic                iom,
        input logic [ADDR_MAX-1:0] base,
        input logic [ADDR_MAX-1:0] mask,
        input logic                io,
        input int unsigned         io_w
    );
        logic [ADDR_MAX-1:0] m;
        m = mask;
        if (io) begin
            m = mask & ~({ADDR_MAX{1'b1}} << io_w);
        end
        return (iom == io) && ((addr & m) == (base & m));
    endfunction

endpackage

// File: rtl/bus_select_unit_decoder.sv
// Combinational priority decode of an address against all windows.
// Ports: i_addr/i_iom in; o_cs one-hot, o_hit, o_wait (winner's waits).
module bus_region_decoder
    import bus_select_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IO_ADDR_W   = DEF_IO_ADDR_W,
    parameter int WS_W        = DEF_WS_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS-1:0]        REGION_IO   = '0,
    parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WAIT = '0
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic                   i_iom,
    output logic [NUM_REGIONS-1:0] o_cs,
    output logic                   o_hit,
    output logic [WS_W-1:0]        o_wait
);

    // Scan high to low so the lowest matching index is kept.
    always_comb begin
        o_cs   = '0;
        o_hit  = 1'b0;
        o_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_hit(ADDR_MAX'(i_addr), i_iom,
                    ADDR_MAX'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                    ADDR_MAX'(REGION_MASK[i*ADDR_W +: ADDR_W]),
                    REGION_IO[i], IO_ADDR_W)) begin
                o_cs    = '0;
                o_cs[i] = 1'b1;
                o_hit   = 1'b1;
                o_wait  = REGION_WAIT[i*WS_W +: WS_W];
            end
        end
    end

endmodule

// File: rtl/bus_select_unit.sv
// 8088 address latch, chip-select decode and per-region READY wait states.
// In: CLK RESET(async,low) ALE IOM A AD RD_N WR_N.
// Out: ADDRESS CS READY MISS.
// MISS_CAPTURE_EN adds MISS_CLR in; MISS_STICKY/MISS_ADDR/MISS_IOM out.
module bus_select_unit
    import bus_select_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IO_ADDR_W   = DEF_IO_ADDR_W,
    parameter int WS_W        = DEF_WS_W,
    // Entry i sits at [i*W +: W]; region 0 is the rightmost field.
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {20'h00000, 20'h08000, 20'h80000, 20'h00000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
        {20'h08000, 20'h08000, 20'h80000, 20'h80000},
    parameter logic [NUM_REGIONS-1:0]        REGION_IO   = 4'b1100,
    parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WAIT =
        {3'd3, 3'd2, 3'd1, 3'd0}
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ALE,
    input  logic                   IOM,
    input  logic [ADDR_W-9:0]      A,
    input  logic [7:0]             AD,
    input  logic                   RD_N,
    input  logic                   WR_N,
    output logic [ADDR_W-1:0]      ADDRESS,
    output logic [NUM_REGIONS-1:0] CS,
    output logic                   READY,
    output logic                   MISS
`ifdef MISS_CAPTURE_EN
    ,
    input  logic                   MISS_CLR,
    output logic                   MISS_STICKY,
    output logic [ADDR_W-1:0]      MISS_ADDR,
    output logic                   MISS_IOM
`endif
);

    logic [ADDR_W-1:0]      w_bus_addr;
    logic [NUM_REGIONS-1:0] w_dec_cs;
    logic                   w_hit;
    logic [WS_W-1:0]        w_dec_wait;
    logic                   w_strobe;

    bus_state_e             r_state, w_state_nx;
    logic [ADDR_W-1:0]      r_address, w_address_nx;
    logic [NUM_REGIONS-1:0] r_cs, w_cs_nx;
    logic [WS_W-1:0]        r_cnt, w_cnt_nx;
    logic                   r_ready, w_ready_nx;
    logic                   r_miss, w_miss_nx;

    assign w_bus_addr = {A, AD};
    assign w_strobe   = !RD_N || !WR_N;

    bus_region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .IO_ADDR_W   (IO_ADDR_W),
        .WS_W        (WS_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .REGION_IO   (REGION_IO),
        .REGION_WAIT (REGION_WAIT)
    ) u_dec (
        .i_addr (w_bus_addr),
        .i_iom  (IOM),
        .o_cs   (w_dec_cs),
        .o_hit  (w_hit),
        .o_wait (w_dec_wait)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_cs      <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_miss    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_address <= w_address_nx;
            r_cs      <= w_cs_nx;
            r_cnt     <= w_cnt_nx;
            r_ready   <= w_ready_nx;
            r_miss    <= w_miss_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_address_nx = r_address;
        w_cs_nx      = r_cs;
        w_cnt_nx     = r_cnt;
        w_ready_nx   = r_ready;
        w_miss_nx    = 1'b0;
        if (ALE) begin
            // ALE restarts from any state; a miss yields zero waits.
            w_address_nx = w_bus_addr;
            w_cs_nx      = w_dec_cs;
            w_cnt_nx     = w_dec_wait;
            w_ready_nx   = 1'b1;
            w_miss_nx    = !w_hit;
            w_state_nx   = ADDR;
        end else begin
            unique case (r_state)
                IDLE: ;
                ADDR: begin
                    if (w_strobe) begin
                        if (r_cnt != '0) begin
                            w_ready_nx = 1'b0;
                            w_state_nx = WAIT;
                        end else begin
                            w_ready_nx = 1'b1;
                            w_state_nx = DATA;
                        end
                    end
                end
                WAIT: begin
                    // Countdown ignores the strobe once started.
                    w_cnt_nx = r_cnt - WS_W'(1);
                    if (r_cnt <= WS_W'(1)) begin
                        w_ready_nx = 1'b1;
                        w_state_nx = DATA;
                    end
                end
                DATA: begin
                    if (RD_N && WR_N) begin
                        w_cs_nx    = '0;
                        w_state_nx = IDLE;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign ADDRESS = r_address;
    assign CS      = r_cs;
    assign READY   = r_ready;
    assign MISS    = r_miss;

`ifdef MISS_CAPTURE_EN
    logic              r_miss_sticky;
    logic [ADDR_W-1:0] r_miss_addr;
    logic              r_miss_iom;

    // Only the first miss is kept; clear wins over a same-cycle miss.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_miss_sticky <= 1'b0;
            r_miss_addr   <= '0;
            r_miss_iom    <= 1'b0;
        end else if (MISS_CLR) begin
            r_miss_sticky <= 1'b0;
            r_miss_addr   <= '0;
            r_miss_iom    <= 1'b0;
        end else if (ALE && !w_hit && !r_miss_sticky) begin
            r_miss_sticky <= 1'b1;
            r_miss_addr   <= w_bus_addr;
            r_miss_iom    <= IOM;
        end
    end

    assign MISS_STICKY = r_miss_sticky;
    assign MISS_ADDR   = r_miss_addr;
    assign MISS_IOM    = r_miss_iom;
`endif

endmodule
